// File: rtl/exec_wb_stage.sv
// Execute/write-back stage: single-cycle ALU plus optional iterative shift-add MUL.
// Define EXEC_MUL_EN to build the multiplier; otherwise op 7 is flagged on op_err.
module exec_wb_stage #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         op,
    input  logic [RADDR_W-1:0] rd,
    input  logic [XLEN-1:0]    rs1_data,
    input  logic [XLEN-1:0]    rs2_data,
    output logic               we,
    output logic [RADDR_W-1:0] waddr,
    output logic [XLEN-1:0]    wbdata,
    output logic               busy,
    output logic               op_err
);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SLT = 3'd5;
    localparam logic [2:0] OP_SLL = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    logic               we_reg, we_next;
    logic [RADDR_W-1:0] waddr_reg, waddr_next;
    logic [XLEN-1:0]    wbdata_reg, wbdata_next;
    logic               op_err_reg, op_err_next;
    logic [XLEN-1:0]    alu_res;
    logic               accept;

    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD: alu_res = rs1_data + rs2_data;
            OP_SUB: alu_res = rs1_data + ~rs2_data + XLEN'(1);
            OP_AND: alu_res = rs1_data & rs2_data;
            OP_OR:  alu_res = rs1_data | rs2_data;
            OP_XOR: alu_res = rs1_data ^ rs2_data;
            OP_SLT: alu_res[0] = $signed(rs1_data) < $signed(rs2_data);
            OP_SLL: alu_res = rs1_data << rs2_data[4:0];
            default: alu_res = '0;
        endcase
    end

`ifdef EXEC_MUL_EN
    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t             state_reg, state_next;
    logic [XLEN-1:0]    mul_a_reg, mul_a_next;
    logic [XLEN-1:0]    mul_b_reg, mul_b_next;
    logic [XLEN-1:0]    acc_reg, acc_next;
    logic [XLEN-1:0]    acc_sum;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic [RADDR_W-1:0] mul_rd_reg, mul_rd_next;

    assign in_ready = (state_reg == S_IDLE) && reset;
    assign busy     = (state_reg == S_MUL);
    assign acc_sum  = acc_reg + (mul_b_reg[0] ? mul_a_reg : '0);
`else
    assign in_ready = reset;
    assign busy     = 1'b0;
`endif

    assign accept = in_valid && in_ready;

    always_comb begin
        we_next     = 1'b0;
        waddr_next  = waddr_reg;
        wbdata_next = wbdata_reg;
        op_err_next = 1'b0;
`ifdef EXEC_MUL_EN
        state_next  = state_reg;
        mul_a_next  = mul_a_reg;
        mul_b_next  = mul_b_reg;
        acc_next    = acc_reg;
        count_next  = count_reg;
        mul_rd_next = mul_rd_reg;
        if (state_reg == S_MUL) begin
            acc_next   = acc_sum;
            mul_a_next = mul_a_reg << 1;
            mul_b_next = mul_b_reg >> 1;
            count_next = count_reg + CNT_W'(1);
            // The last step writes the updated sum directly, not acc_reg.
            if (count_reg == CNT_W'(XLEN - 1)) begin
                wbdata_next = acc_sum;
                waddr_next  = mul_rd_reg;
                we_next     = (mul_rd_reg != '0);
                state_next  = S_IDLE;
            end
        end else
`endif
        if (accept) begin
            if (op == OP_MUL) begin
`ifdef EXEC_MUL_EN
                mul_a_next  = rs1_data;
                mul_b_next  = rs2_data;
                acc_next    = '0;
                count_next  = '0;
                mul_rd_next = rd;
                state_next  = S_MUL;
`else
                op_err_next = 1'b1;
`endif
            end else begin
                waddr_next  = rd;
                wbdata_next = alu_res;
                we_next     = (rd != '0);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_reg     <= 1'b0;
            waddr_reg  <= '0;
            wbdata_reg <= '0;
            op_err_reg <= 1'b0;
`ifdef EXEC_MUL_EN
            state_reg  <= S_IDLE;
            mul_a_reg  <= '0;
            mul_b_reg  <= '0;
            acc_reg    <= '0;
            count_reg  <= '0;
            mul_rd_reg <= '0;
`endif
        end else begin
            we_reg     <= we_next;
            waddr_reg  <= waddr_next;
            wbdata_reg <= wbdata_next;
            op_err_reg <= op_err_next;
`ifdef EXEC_MUL_EN
            state_reg  <= state_next;
            mul_a_reg  <= mul_a_next;
            mul_b_reg  <= mul_b_next;
            acc_reg    <= acc_next;
            count_reg  <= count_next;
            mul_rd_reg <= mul_rd_next;
`endif
        end
    end

    assign we     = we_reg;
    assign waddr  = waddr_reg;
    assign wbdata = wbdata_reg;
    assign op_err = op_err_reg;

endmodule

// File: tb/tb_exec_wb_stage.sv
// Directed bench for exec_wb_stage; a queue scoreboard checks every register-file write.
// The MUL section runs only when EXEC_MUL_EN is defined, otherwise the op-7 error path is checked.
module tb_exec_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [4:0]  rd;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wbdata;
    logic        busy;
    logic        op_err;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    exec_wb_stage #(.XLEN(32), .RADDR_W(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .rd       (rd),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .we       (we),
        .waddr    (waddr),
        .wbdata   (wbdata),
        .busy     (busy),
        .op_err   (op_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] o, input logic [4:0] r,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic push, input logic [31:0] exp_data);
        op       = o;
        rd       = r;
        rs1_data = a;
        rs2_data = b;
        in_valid = 1'b1;
        if (push) sb_q.push_back('{addr: r, data: exp_data});
    endtask

    // Scoreboard: every write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (we === 1'b1) begin
            chk("sb_pending", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_waddr", 32'(waddr), 32'(e.addr));
                chk("sb_wbdata", wbdata, e.data);
                $display("write x%0d = 0x%08h (expected x%0d = 0x%08h)", waddr, wbdata, e.addr, e.data);
            end
        end
    end

    initial begin
        int          wait_cycles;
        int          busy_cycles;
        int          early_we;
        logic [31:0] prev_data;

        reset    = 1'b0;
        in_valid = 1'b1;
        op       = 3'd0;
        rd       = 5'd3;
        rs1_data = 32'd5;
        rs2_data = 32'd7;

        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_in_ready", 32'(in_ready), 32'd0);
            chk("rst_we", 32'(we), 32'd0);
            chk("rst_waddr", 32'(waddr), 32'd0);
            chk("rst_wbdata", wbdata, 32'd0);
            chk("rst_busy_err", {30'd0, busy, op_err}, 32'd0);
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("idle_we", 32'(we), 32'd0);

        // Back-to-back single-cycle ops
        drive(3'd0, 5'd3, 32'd5, 32'd7, 1'b1, 32'd12);
        tick();
        chk("add_we", 32'(we), 32'd1);
        chk("add_data", wbdata, 32'd12);
        drive(3'd1, 5'd4, 32'd5, 32'd7, 1'b1, 32'hFFFF_FFFE);
        tick();
        chk("sub_we", 32'(we), 32'd1);
        chk("sub_data", wbdata, 32'hFFFF_FFFE);
        drive(3'd5, 5'd5, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'd1);
        tick();
        chk("slt_we", 32'(we), 32'd1);
        chk("slt_addr", 32'(waddr), 32'd5);
        chk("slt_data", wbdata, 32'd1);
        chk("alu_op_err", 32'(op_err), 32'd0);
        in_valid = 1'b0;
        tick();
        chk("hold_we", 32'(we), 32'd0);
        chk("hold_addr", 32'(waddr), 32'd5);
        chk("hold_data", wbdata, 32'd1);

        drive(3'd6, 5'd6, 32'd1, 32'h23, 1'b1, 32'd8);
        tick();
        chk("sll_we", 32'(we), 32'd1);
        chk("sll_data", wbdata, 32'd8);
        drive(3'd4, 5'd11, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b1, 32'hFF00_EDCB);
        tick();
        chk("xor_data", wbdata, 32'hFF00_EDCB);

        // Writes to x0 are suppressed but the data path still updates
        drive(3'd0, 5'd0, 32'd1, 32'd1, 1'b0, 32'd0);
        tick();
        chk("x0_we", 32'(we), 32'd0);
        chk("x0_addr", 32'(waddr), 32'd0);
        chk("x0_data", wbdata, 32'd2);
        in_valid = 1'b0;
        tick();

`ifdef EXEC_MUL_EN
        drive(3'd7, 5'd7, 32'h0001_2345, 32'h10, 1'b1, 32'h0012_3450);
        tick();
        in_valid    = 1'b0;
        busy_cycles = 0;
        early_we    = 0;
        for (int i = 0; i < 32; i++) begin
            if (busy === 1'b1 && in_ready === 1'b0) busy_cycles++;
            if (we === 1'b1) early_we++;
            tick();
        end
        chk("mul_busy_cycles", 32'(busy_cycles), 32'd32);
        chk("mul_early_we", 32'(early_we), 32'd0);
        chk("mul_we", 32'(we), 32'd1);
        chk("mul_data", wbdata, 32'h0012_3450);
        chk("mul_in_ready", 32'(in_ready), 32'd1);
        chk("mul_busy_end", 32'(busy), 32'd0);
        tick();

        // Second MUL with an ADD held at the input the whole time
        drive(3'd7, 5'd8, 32'hFFFF_FFFF, 32'd2, 1'b1, 32'hFFFF_FFFE);
        tick();
        drive(3'd0, 5'd2, 32'd10, 32'd20, 1'b1, 32'd30);
        wait_cycles = 0;
        while (we !== 1'b1 && wait_cycles < 40) begin
            tick();
            wait_cycles++;
        end
        chk("mul2_latency", 32'(wait_cycles), 32'd32);
        chk("mul2_data", wbdata, 32'hFFFF_FFFE);
        tick();
        in_valid = 1'b0;
        chk("stall_we", 32'(we), 32'd1);
        chk("stall_addr", 32'(waddr), 32'd2);
        chk("stall_data", wbdata, 32'd30);
        tick();
        chk("stall_once", 32'(we), 32'd0);

        // Reset during a MUL aborts it with no write
        drive(3'd7, 5'd9, 32'd3, 32'd5, 1'b0, 32'd0);
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        reset = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_we", 32'(we), 32'd0);
        chk("abort_data", wbdata, 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        drive(3'd0, 5'd10, 32'd100, 32'd23, 1'b1, 32'd123);
        tick();
        in_valid = 1'b0;
        chk("post_abort_data", wbdata, 32'd123);
        drive(3'd7, 5'd12, 32'd6, 32'd7, 1'b1, 32'd42);
        tick();
        in_valid = 1'b0;
        repeat (32) tick();
        chk("post_abort_mul", wbdata, 32'd42);
`else
        prev_data = wbdata;
        drive(3'd7, 5'd7, 32'h0001_2345, 32'h10, 1'b0, 32'd0);
        #1;
        chk("mul_off_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("mul_off_op_err", 32'(op_err), 32'd1);
        chk("mul_off_we", 32'(we), 32'd0);
        chk("mul_off_data", wbdata, prev_data);
        chk("mul_off_busy", 32'(busy), 32'd0);
        chk("mul_off_ready2", 32'(in_ready), 32'd1);
        tick();
        chk("mul_off_err_pulse", 32'(op_err), 32'd0);
        drive(3'd0, 5'd10, 32'd100, 32'd23, 1'b1, 32'd123);
        tick();
        in_valid = 1'b0;
        chk("after_err_data", wbdata, 32'd123);
`endif

        repeat (3) tick();
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
